// File: rtl/lab02_key_cond.sv
// lab02_key_cond: conditions four raw push-buttons for the lab02_wave lock.
// Each button is synchronised, debounced and edge-detected; a small FSM
// accepts one key per press and emits a single-cycle one-hot strobe.
// A press of two or more keys in the same cycle raises multi_err.
// After any accepted or rejected press, a new key is taken only once
// every key has been released.

module lab02_key_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       clean,
    input  logic [3:0] btn,
    output logic       X0,
    output logic       X1,
    output logic       X2,
    output logic       X3,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       multi_err
);

    // A level change is accepted on the cycle the counter would reach
    // DEBOUNCE_CYCLES, which is the cycle where it already holds this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       db;
    logic [3:0]       db_q;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt [4];
    logic [2:0]       rise_cnt;
    logic [1:0]       rise_code;

    logic [3:0]       x_nxt;
    logic             valid_nxt;
    logic [1:0]       code_nxt;
    logic             merr_nxt;

    logic [3:0]       x_q;
    logic             valid_q;
    logic [1:0]       code_q;
    logic             merr_q;

    // Number of bits set in a 4-bit vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one is set.
    function automatic logic [1:0] encode4(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (!clean) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Per-bit debounce: db follows s2 only after the change has persisted.
    always_ff @(posedge clk) begin
        if (!clean) begin
            db <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!clean) begin
            db_q <= '0;
        end else begin
            db_q <= db;
        end
    end

    // Rising edges of the debounced levels and their summary.
    always_comb begin
        rise      = db & ~db_q;
        rise_cnt  = popcount4(rise);
        rise_code = encode4(rise);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!clean) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: any press leaves IDLE, full release leaves HELD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise_cnt != 3'd0) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (db == 4'b0000) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered strobes.
    always_comb begin
        x_nxt     = '0;
        valid_nxt = 1'b0;
        code_nxt  = '0;
        merr_nxt  = 1'b0;
        if (state == IDLE) begin
            if (rise_cnt == 3'd1) begin
                x_nxt     = rise;
                valid_nxt = 1'b1;
                code_nxt  = rise_code;
            end else if (rise_cnt >= 3'd2) begin
                merr_nxt  = 1'b1;
            end
        end
    end

    // Output registers; every strobe lasts one cycle since the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        if (!clean) begin
            x_q     <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            merr_q  <= 1'b0;
        end else begin
            x_q     <= x_nxt;
            valid_q <= valid_nxt;
            code_q  <= code_nxt;
            merr_q  <= merr_nxt;
        end
    end

    assign X0        = x_q[0];
    assign X1        = x_q[1];
    assign X2        = x_q[2];
    assign X3        = x_q[3];
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign multi_err = merr_q;

endmodule

// File: tb/tb_lab02_key_cond.sv
// Directed bench for lab02_key_cond with DEBOUNCE_CYCLES=4.
// Each press pushes its expected output word and the cycle it is due;
// every cycle with a due entry or any active output is compared.

module tb_lab02_key_cond;

    logic       clk;
    logic       clean;
    logic [3:0] btn;
    logic       X0, X1, X2, X3;
    logic       key_valid;
    logic [1:0] key_code;
    logic       multi_err;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  vec;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;

    lab02_key_cond #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .clean    (clean),
        .btn      (btn),
        .X0       (X0),
        .X1       (X1),
        .X2       (X2),
        .X3       (X3),
        .key_valid(key_valid),
        .key_code (key_code),
        .multi_err(multi_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Output word: {X3,X2,X1,X0,key_valid,key_code,multi_err}.
    function automatic logic [7:0] key_word(input int unsigned k);
        logic [7:0] v;
        v        = '0;
        v[4 + k] = 1'b1;
        v[3]     = 1'b1;
        v[2:1]   = 2'(k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Advance one edge, then compare outputs against the scoreboard.
    task automatic tick();
        logic [7:0] obs;
        logic [7:0] want;
        exp_t       e;
        @(posedge clk);
        cyc++;
        #1;
        obs  = {X3, X2, X1, X0, key_valid, key_code, multi_err};
        want = '0;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e    = sb.pop_front();
            want = e.vec;
        end
        if (obs != 8'h00 || want != 8'h00) begin
            check("strobe", {24'h0, obs}, {24'h0, want});
        end
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Drive a new button pattern; the next edge is the first sample, the
    // strobe registers six edges after that.
    task automatic press(input logic [3:0] b, input logic [7:0] expect_vec);
        exp_t e;
        btn = b;
        if (expect_vec != 8'h00) begin
            e.cyc = cyc + 7;
            e.vec = expect_vec;
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [7:0] obs;
        cyc      = 0;
        checks   = 0;
        failures = 0;
        btn      = 4'b0000;
        clean    = 1'b0;

        // Reset
        ticks(3);
        obs = {X3, X2, X1, X0, key_valid, key_code, multi_err};
        check("reset_outputs", {24'h0, obs}, 32'h0);
        check("reset_db", {28'h0, dut.db}, 32'h0);
        clean = 1'b1;
        ticks(2);

        // 1: single key 2, held 10 cycles
        press(4'b0100, key_word(2));
        ticks(10);
        btn = 4'b0000;
        ticks(8);

        // 2: glitches of 3 and 2 cycles never change db[0]
        press(4'b0001, 8'h00);
        ticks(3);
        btn = 4'b0000;
        ticks(1);
        btn = 4'b0001;
        ticks(2);
        check("glitch_db0_a", {31'h0, dut.db[0]}, 32'h0);
        btn = 4'b0000;
        ticks(8);
        check("glitch_db0_b", {31'h0, dut.db[0]}, 32'h0);

        // 3: X0, X0, X3 sequence
        press(4'b0001, key_word(0));
        ticks(8);
        btn = 4'b0000;
        ticks(8);
        press(4'b0001, key_word(0));
        ticks(8);
        btn = 4'b0000;
        ticks(8);
        press(4'b1000, key_word(3));
        ticks(8);
        btn = 4'b0000;
        ticks(8);

        // 4: simultaneous press, partial release, then clean re-press
        press(4'b0110, 8'h01);
        ticks(8);
        btn = 4'b0100;
        ticks(10);
        btn = 4'b0000;
        ticks(8);
        press(4'b0100, key_word(2));
        ticks(8);
        btn = 4'b0000;
        ticks(8);

        // 5: second key while first is held is never accepted
        press(4'b0010, key_word(1));
        ticks(7);
        ticks(3);
        btn = 4'b1010;
        ticks(8);
        btn = 4'b1000;
        ticks(10);
        btn = 4'b0000;
        ticks(8);
        press(4'b1000, key_word(3));
        ticks(8);
        btn = 4'b0000;
        ticks(8);

        // 6: reset while held in HELD, key re-debounces and strobes once
        press(4'b0100, key_word(2));
        ticks(8);
        clean = 1'b0;
        ticks(1);
        obs = {X3, X2, X1, X0, key_valid, key_code, multi_err};
        check("midreset_outputs", {24'h0, obs}, 32'h0);
        check("midreset_db", {28'h0, dut.db}, 32'h0);
        clean = 1'b1;
        press(4'b0100, key_word(2));
        ticks(10);
        btn = 4'b0000;
        ticks(8);

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
